transposicao_matriz_serial: RTL and testbench

//   Streaming, parametrised successor of the flat-bus 5x5 transpose block.

---
 rtl/transposicao_matriz_serial.sv | 141 ++++++++++++++
 tb/tb_transposicao_matriz_serial.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/transposicao_matriz_serial.sv
// Streaming NxN matrix buffer: loads one element per cycle in row-major order,
// then drains the whole frame either transposed (column-major) or unchanged.
module transposicao_matriz_serial #(
    parameter int N    = 5,
    parameter int W    = 8,
    parameter int FC_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [FC_W-1:0] frames_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    typedef enum logic {
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_r_q, wr_r_d, wr_c_q, wr_c_d;
    logic [IW-1:0]   rd_r_q, rd_r_d, rd_c_q, rd_c_d;
    logic            mode_q, mode_d;
    logic [FC_W-1:0] frames_q, frames_d;
    logic [W-1:0]    mem_q [N][N];

    logic            in_fire;
    logic            out_fire;
    logic            wr_at_end;
    logic            rd_at_end;
    logic [W-1:0]    rd_elem;

    assign in_fire   = in_valid && (state_q == S_LOAD);
    assign out_fire  = out_ready && (state_q == S_DRAIN);
    assign wr_at_end = (wr_r_q == IDX_MAX) && (wr_c_q == IDX_MAX);
    assign rd_at_end = (rd_r_q == IDX_MAX) && (rd_c_q == IDX_MAX);

    // Transpose is a read-side index swap; storage is always row-major.
    assign rd_elem = mode_q ? mem_q[rd_c_q][rd_r_q] : mem_q[rd_r_q][rd_c_q];

    // Handshake outputs depend only on state and reset, never on the partner's valid/ready.
    assign in_ready    = !reset && (state_q == S_LOAD);
    assign out_valid   = !reset && (state_q == S_DRAIN);
    assign out_data    = out_valid ? rd_elem : '0;
    assign out_last    = out_valid && rd_at_end;
    assign frames_done = frames_q;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d  = state_q;
        wr_r_d   = wr_r_q;
        wr_c_d   = wr_c_q;
        rd_r_d   = rd_r_q;
        rd_c_d   = rd_c_q;
        mode_d   = mode_q;
        frames_d = frames_q;

        case (state_q)
            S_LOAD: begin
                if (in_fire) begin
                    if ((wr_r_q == '0) && (wr_c_q == '0)) begin
                        mode_d = mode;
                    end
                    if (wr_at_end) begin
                        wr_r_d  = '0;
                        wr_c_d  = '0;
                        state_d = S_DRAIN;
                    end else if (wr_c_q == IDX_MAX) begin
                        wr_c_d = '0;
                        wr_r_d = wr_r_q + IW'(1);
                    end else begin
                        wr_c_d = wr_c_q + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (rd_at_end) begin
                        rd_r_d   = '0;
                        rd_c_d   = '0;
                        frames_d = frames_q + FC_W'(1);
                        state_d  = S_LOAD;
                    end else if (rd_c_q == IDX_MAX) begin
                        rd_c_d = '0;
                        rd_r_d = rd_r_q + IW'(1);
                    end else begin
                        rd_c_d = rd_c_q + IW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOAD;
            wr_r_q   <= '0;
            wr_c_q   <= '0;
            rd_r_q   <= '0;
            rd_c_q   <= '0;
            mode_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_r_q   <= wr_r_d;
            wr_c_q   <= wr_c_d;
            rd_r_q   <= rd_r_d;
            rd_c_q   <= rd_c_d;
            mode_q   <= mode_d;
            frames_q <= frames_d;
        end
    end

    // NOTE: the element array is reset explicitly so a frame cut short by reset
    // can never leak stale data; it costs a reset net on every storage flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else if (in_fire) begin
            mem_q[wr_r_q][wr_c_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_transposicao_matriz_serial.sv
// Self-checking bench for transposicao_matriz_serial: directed and randomized
// frames compared against an index-arithmetic reference of transpose/pass-through.
module tb_transposicao_matriz_serial;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int NN = N * N;

    typedef logic [W-1:0] frame_t [NN];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [15:0]  frames_done;

    logic         mode3 = 1'b0;
    logic         in_valid3 = 1'b0;
    logic         in_ready3;
    logic [15:0]  in_data3 = '0;
    logic         out_valid3;
    logic         out_ready3 = 1'b0;
    logic [15:0]  out_data3;
    logic         out_last3;
    logic [15:0]  frames_done3;

    int n_total = 0;
    int n_pass  = 0;

    transposicao_matriz_serial #(.N(N), .W(W), .FC_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .frames_done (frames_done)
    );

    transposicao_matriz_serial #(.N(3), .W(16), .FC_W(16)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode3),
        .in_valid    (in_valid3),
        .in_ready    (in_ready3),
        .in_data     (in_data3),
        .out_valid   (out_valid3),
        .out_ready   (out_ready3),
        .out_data    (out_data3),
        .out_last    (out_last3),
        .frames_done (frames_done3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: output k of a frame is element (row k/N, col k%N) of the
    // matrix, or of its transpose, which lives at source index (k%N)*N + k/N.
    function automatic frame_t expected_frame(input frame_t src, input logic m);
        frame_t dst;
        for (int k = 0; k < NN; k++) begin
            dst[k] = m ? src[(k % N) * N + (k / N)] : src[k];
        end
        return dst;
    endfunction

    function automatic frame_t neg_frame();
        frame_t f;
        for (int i = 0; i < NN; i++) f[i] = W'(-(i + 1));
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < NN; i++) f[i] = W'($urandom);
        return f;
    endfunction

    // Called and returns on a falling edge; presents `count` elements with optional gaps.
    task automatic load_frame(input frame_t f, input logic m0, input int flip_at,
                              input int gap_pct, input int count);
        for (int i = 0; i < count; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = f[i];
            mode     = (i < flip_at) ? m0 : ~m0;
            begin
                int budget = 0;
                while (!in_ready && budget < 100) begin
                    @(negedge clk);
                    budget++;
                end
            end
            check("load_in_ready", 32'(in_ready), 32'd1);
            check("load_no_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // rdy_mode: 0 = always ready, 1 = toggling starting low, 2 = random.
    task automatic drain_frame(input frame_t e, input int rdy_mode, output int cycles);
        cycles = 0;
        for (int k = 0; k < NN; k++) begin
            bit done = 1'b0;
            int budget = 0;
            while (!done && budget < 200) begin
                case (rdy_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (cycles % 2) == 1;
                    default: out_ready = 1'($urandom_range(1));
                endcase
                check("drain_out_valid", 32'(out_valid), 32'd1);
                check("drain_out_data", 32'(out_data), 32'(e[k]));
                check("drain_out_last", 32'(out_last), 32'(k == NN - 1));
                check("drain_in_ready", 32'(in_ready), 32'd0);
                done = out_ready;
                cycles++;
                budget++;
                @(negedge clk);
            end
            if (!done) check("drain_timeout", 32'd0, 32'd1);
        end
        out_ready = 1'b0;
    endtask

    task automatic full_frame(input frame_t f, input logic m0, input int flip_at,
                              input int gap_pct, input int rdy_mode, input int fd_exp,
                              output int cycles);
        load_frame(f, m0, flip_at, gap_pct, NN);
        check("first_out_latency", 32'(out_valid), 32'd1);
        check("in_ready_low_after_load", 32'(in_ready), 32'd0);
        drain_frame(expected_frame(f, m0), rdy_mode, cycles);
        check("in_ready_after_drain", 32'(in_ready), 32'd1);
        check("out_valid_after_drain", 32'(out_valid), 32'd0);
        check("frames_done", 32'(frames_done), 32'(fd_exp));
    endtask

    initial begin
        frame_t f3;
        int     cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_frames_done", 32'(frames_done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // 1: transpose, no stalls; 2: pass-through
        full_frame(neg_frame(), 1'b1, NN, 0, 0, 1, cyc);
        check("t1_drain_cycles", 32'(cyc), 32'(NN));
        full_frame(neg_frame(), 1'b0, NN, 0, 0, 2, cyc);
        check("t2_drain_cycles", 32'(cyc), 32'(NN));

        // 3: transpose with out_ready toggling
        full_frame(neg_frame(), 1'b1, NN, 0, 1, 3, cyc);
        check("t3_drain_cycles", 32'(cyc), 32'(2 * NN));

        // 4: random data, input gaps, mode flipped after element 3, random backpressure
        full_frame(rand_frame(), 1'b1, 3, 30, 2, 4, cyc);
        full_frame(rand_frame(), 1'b0, 3, 30, 2, 5, cyc);

        // 5: reset after 12 accepted elements, then a fresh frame
        load_frame(neg_frame(), 1'b1, NN, 0, 12);
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_frames_done", 32'(frames_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        full_frame(neg_frame(), 1'b1, NN, 0, 0, 1, cyc);

        // 6: N=3, W=16 instance, transpose of 1..9
        for (int i = 0; i < 9; i++) begin
            in_valid3 = 1'b1;
            in_data3  = 16'(i + 1);
            mode3     = 1'b1;
            check("n3_in_ready", 32'(in_ready3), 32'd1);
            @(negedge clk);
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("n3_out_valid", 32'(out_valid3), 32'd1);
            check("n3_out_data", 32'(out_data3), 32'((k % 3) * 3 + (k / 3) + 1));
            check("n3_out_last", 32'(out_last3), 32'(k == 8));
            @(negedge clk);
        end
        out_ready3 = 1'b0;
        check("n3_frames_done", 32'(frames_done3), 32'd1);
        check("n3_in_ready_after", 32'(in_ready3), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
